// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: HTRANS encodings and the command/response records
// used by the initiator and by the blocks that talk to it.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam int AHB_ADDR_W = 32;
    localparam int AHB_DATA_W = 32;

    typedef struct packed {
        logic                  write;
        logic [AHB_ADDR_W-1:0] addr;
        logic [AHB_DATA_W-1:0] wdata;
    } ahb_cmd_t;

    typedef struct packed {
        logic                  write;
        logic [AHB_DATA_W-1:0] rdata;
        logic                  err;
    } ahb_rsp_t;

endpackage

// File: rtl/ahb_init_timeout.sv
// Wait-state watchdog for the initiator data phase: counts consecutive stalled
// cycles and raises a combinational abort on the edge that reaches the limit.
module ahb_init_timeout #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_stall,
    output logic o_abort
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] r_cnt;

    // The edge that would make the count equal TIMEOUT_CYC is the aborting edge.
    assign o_abort = i_stall && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (!i_stall || o_abort) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ahb_lite_initiator.sv
// Single-master AHB-Lite initiator: valid/ready command stream in, pipelined
// NONSEQ transfers out, one registered response per command. AHB_INIT_TIMEOUT_EN
// adds a data-phase wait-state timeout that completes the transfer with rsp_err.
module ahb_lite_initiator
    import ahb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              HSEL,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [DATA_W-1:0] HWDATA,
    output logic              HREADY,
    input  logic              HREADYOUT,
    input  logic [DATA_W-1:0] HRDATA
);

    // Command handshake: a command transfers on any edge where cmd_valid && cmd_ready.
    logic              r_ap_valid;
    logic              r_ap_write;
    logic [ADDR_W-1:0] r_ap_addr;
    logic [DATA_W-1:0] r_ap_wdata;
    logic              r_dp_valid;
    logic              r_dp_write;
    logic [DATA_W-1:0] r_dp_wdata;
    logic              r_rsp_valid;
    logic              r_rsp_write;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;

    logic w_abort;
    logic w_advance;
    logic w_accept;
    logic w_complete;

`ifdef AHB_INIT_TIMEOUT_EN
    ahb_init_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .i_stall(r_dp_valid && !HREADYOUT),
        .o_abort(w_abort)
    );
`else
    assign w_abort = 1'b0;
`endif

    // An abort moves the pipeline exactly as a ready slave would.
    assign w_advance  = HREADYOUT || w_abort;
    assign cmd_ready  = !r_ap_valid || w_advance;
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_complete = r_dp_valid && w_advance;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ap_valid <= 1'b0;
            r_ap_write <= 1'b0;
            r_ap_addr  <= '0;
            r_ap_wdata <= '0;
            r_dp_valid <= 1'b0;
            r_dp_write <= 1'b0;
            r_dp_wdata <= '0;
        end else begin
            if (w_advance) begin
                r_dp_valid <= r_ap_valid;
                r_dp_write <= r_ap_write;
                r_dp_wdata <= r_ap_wdata;
                r_ap_valid <= w_accept;
            end else if (w_accept) begin
                r_ap_valid <= 1'b1;
            end
            // Address fields only change on accept so HADDR/HWRITE hold while idle.
            if (w_accept) begin
                r_ap_write <= cmd_write;
                r_ap_addr  <= cmd_addr;
                r_ap_wdata <= cmd_wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= w_complete;
            if (w_complete) begin
                r_rsp_write <= r_dp_write;
                r_rsp_rdata <= (r_dp_write || w_abort) ? '0 : HRDATA;
                r_rsp_err   <= w_abort;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_write = r_rsp_write;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

    assign HSEL   = r_ap_valid;
    assign HTRANS = r_ap_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDR  = r_ap_addr;
    assign HWRITE = r_ap_write;
    assign HWDATA = r_dp_valid ? r_dp_wdata : '0;
    assign HREADY = HREADYOUT;

endmodule

// File: tb/tb_ahb_lite_initiator.sv
// Directed bench for ahb_lite_initiator: a per-cycle vector table for the
// pipelined traffic, then hand-written stall, timeout and reset sequences.
module tb_ahb_lite_initiator;
    import ahb_pkg::*;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;

    int n_pass  = 0;
    int n_total = 0;

    ahb_lite_initiator #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .TIMEOUT_CYC(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .HSEL     (HSEL),
        .HADDR    (HADDR),
        .HTRANS   (HTRANS),
        .HWRITE   (HWRITE),
        .HWDATA   (HWDATA),
        .HREADY   (HREADY),
        .HREADYOUT(HREADYOUT),
        .HRDATA   (HRDATA)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        cv;
        ahb_cmd_t    cmd;
        logic        hr;
        logic [31:0] hrd;
        logic        e_rdy;
        logic        e_rv;
        logic        e_rw;
        logic [31:0] e_rd;
        logic        e_hsel;
        logic [1:0]  e_ht;
        logic [31:0] e_haddr;
        logic        e_hw;
        logic [31:0] e_hwd;
    } vec_t;

    localparam int NVEC = 26;
    vec_t vecs[NVEC];

    function automatic vec_t v(input logic cv, input logic cw, input logic [31:0] ca,
                               input logic [31:0] cd, input logic hr, input logic [31:0] hrd,
                               input logic e_rdy, input logic e_rv, input logic e_rw,
                               input logic [31:0] e_rd, input logic e_hsel, input logic [1:0] e_ht,
                               input logic [31:0] e_haddr, input logic e_hw, input logic [31:0] e_hwd);
        vec_t r;
        r.cv        = cv;
        r.cmd.write = cw;
        r.cmd.addr  = ca;
        r.cmd.wdata = cd;
        r.hr        = hr;
        r.hrd       = hrd;
        r.e_rdy     = e_rdy;
        r.e_rv      = e_rv;
        r.e_rw      = e_rw;
        r.e_rd      = e_rd;
        r.e_hsel    = e_hsel;
        r.e_ht      = e_ht;
        r.e_haddr   = e_haddr;
        r.e_hw      = e_hw;
        r.e_hwd     = e_hwd;
        return r;
    endfunction

    // driver tasks
    task automatic drive(input logic cv, input logic cw, input logic [31:0] ca,
                         input logic [31:0] cd, input logic hr, input logic [31:0] hrd);
        cmd_valid = cv;
        cmd_write = cw;
        cmd_addr  = ca;
        cmd_wdata = cd;
        HREADYOUT = hr;
        HRDATA    = hrd;
    endtask

    // scoreboard
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [127:0] pack(input logic rdy, input logic rv, input logic rw,
                                          input logic [31:0] rd, input logic err, input logic hsel,
                                          input logic [1:0] ht, input logic [31:0] haddr,
                                          input logic hw, input logic [31:0] hwd);
        return {24'b0, rdy, rv, rw, rd, err, hsel, ht, haddr, hw, hwd};
    endfunction

    localparam logic [1:0] I = HTRANS_IDLE;
    localparam logic [1:0] N = HTRANS_NONSEQ;

    initial begin
        int bad;
        logic [127:0] act;
        logic [127:0] exp;

        // Single write then read to 0x10, no wait states
        vecs[0]  = v(0,0,32'h0, 32'h0,  1,32'h0,    1,0,0,32'h0,    0,I,32'h0, 0,32'h0);
        vecs[1]  = v(1,1,32'h10,32'hA5, 1,32'h0,    1,0,0,32'h0,    0,I,32'h0, 0,32'h0);
        vecs[2]  = v(1,0,32'h10,32'h0,  1,32'h0,    1,0,0,32'h0,    1,N,32'h10,1,32'h0);
        vecs[3]  = v(0,0,32'h0, 32'h0,  1,32'h0,    1,0,0,32'h0,    1,N,32'h10,0,32'hA5);
        vecs[4]  = v(0,0,32'h0, 32'h0,  1,32'hA5,   1,1,1,32'h0,    0,I,32'h10,0,32'h0);
        vecs[5]  = v(0,0,32'h0, 32'h0,  1,32'h0,    1,1,0,32'hA5,   0,I,32'h10,0,32'h0);
        vecs[6]  = v(0,0,32'h0, 32'h0,  1,32'h0,    1,0,0,32'h0,    0,I,32'h10,0,32'h0);
        // Four back-to-back reads
        vecs[7]  = v(1,0,32'h20,32'h0,  1,32'h0,    1,0,0,32'h0,    0,I,32'h10,0,32'h0);
        vecs[8]  = v(1,0,32'h24,32'h0,  1,32'h0,    1,0,0,32'h0,    1,N,32'h20,0,32'h0);
        vecs[9]  = v(1,0,32'h28,32'h0,  1,32'h1020, 1,0,0,32'h0,    1,N,32'h24,0,32'h0);
        vecs[10] = v(1,0,32'h2C,32'h0,  1,32'h1024, 1,1,0,32'h1020, 1,N,32'h28,0,32'h0);
        vecs[11] = v(0,0,32'h0, 32'h0,  1,32'h1028, 1,1,0,32'h1024, 1,N,32'h2C,0,32'h0);
        vecs[12] = v(0,0,32'h0, 32'h0,  1,32'h102C, 1,1,0,32'h1028, 0,I,32'h2C,0,32'h0);
        vecs[13] = v(0,0,32'h0, 32'h0,  1,32'h0,    1,1,0,32'h102C, 0,I,32'h2C,0,32'h0);
        vecs[14] = v(0,0,32'h0, 32'h0,  1,32'h0,    1,0,0,32'h0,    0,I,32'h2C,0,32'h0);
        // Two writes, 3 wait states on the second; a read waits in the address stage
        vecs[15] = v(1,1,32'h30,32'h11, 1,32'h0,    1,0,0,32'h0,    0,I,32'h2C,0,32'h0);
        vecs[16] = v(1,1,32'h34,32'h22, 1,32'h0,    1,0,0,32'h0,    1,N,32'h30,1,32'h0);
        vecs[17] = v(1,0,32'h38,32'h0,  1,32'h0,    1,0,0,32'h0,    1,N,32'h34,1,32'h11);
        vecs[18] = v(1,0,32'h3C,32'h0,  0,32'h0,    0,1,1,32'h0,    1,N,32'h38,0,32'h22);
        vecs[19] = v(1,0,32'h3C,32'h0,  0,32'h0,    0,0,0,32'h0,    1,N,32'h38,0,32'h22);
        vecs[20] = v(1,0,32'h3C,32'h0,  0,32'h0,    0,0,0,32'h0,    1,N,32'h38,0,32'h22);
        vecs[21] = v(1,0,32'h3C,32'h0,  1,32'h0,    1,0,0,32'h0,    1,N,32'h38,0,32'h22);
        vecs[22] = v(0,0,32'h0, 32'h0,  1,32'h1038, 1,1,1,32'h0,    1,N,32'h3C,0,32'h0);
        vecs[23] = v(0,0,32'h0, 32'h0,  1,32'h103C, 1,1,0,32'h1038, 0,I,32'h3C,0,32'h0);
        vecs[24] = v(0,0,32'h0, 32'h0,  1,32'h0,    1,1,0,32'h103C, 0,I,32'h3C,0,32'h0);
        vecs[25] = v(0,0,32'h0, 32'h0,  1,32'h0,    1,0,0,32'h0,    0,I,32'h3C,0,32'h0);

        reset = 1'b1;
        drive(0, 0, 32'h0, 32'h0, 1, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        chk("reset_state",
            pack(cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err, HSEL, HTRANS, HADDR, HWRITE, HWDATA),
            pack(1, 0, 0, 32'h0, 0, 0, I, 32'h0, 0, 32'h0));
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].cv, vecs[i].cmd.write, vecs[i].cmd.addr, vecs[i].cmd.wdata,
                  vecs[i].hr, vecs[i].hrd);
            #1;
            act = pack(cmd_ready, rsp_valid,
                       vecs[i].e_rv ? rsp_write : vecs[i].e_rw,
                       vecs[i].e_rv ? rsp_rdata : vecs[i].e_rd,
                       vecs[i].e_rv ? rsp_err : 1'b0,
                       HSEL, HTRANS, HADDR, HWRITE, HWDATA);
            exp = pack(vecs[i].e_rdy, vecs[i].e_rv, vecs[i].e_rw, vecs[i].e_rd, 1'b0,
                       vecs[i].e_hsel, vecs[i].e_ht, vecs[i].e_haddr, vecs[i].e_hw, vecs[i].e_hwd);
            chk($sformatf("vec%0d", i), act, exp);
            @(negedge clk);
        end

        // Long stall: read 0x50 in data phase, read 0x54 in address phase
        drive(1, 0, 32'h50, 32'h0, 1, 32'h0);
        @(negedge clk);
        drive(1, 0, 32'h54, 32'h0, 1, 32'h0);
        @(negedge clk);
`ifndef AHB_INIT_TIMEOUT_EN
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            drive(1, 0, 32'h58, 32'h0, 0, 32'hFFFF);
            #1;
            if (HSEL !== 1'b1 || HTRANS !== N || HADDR !== 32'h54 || HWRITE !== 1'b0 ||
                HWDATA !== 32'h0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("stall_freeze_100", 128'(bad), 128'd0);
        drive(0, 0, 32'h0, 32'h0, 1, 32'h1050);
        @(negedge clk);
        drive(0, 0, 32'h0, 32'h0, 1, 32'h1054);
        #1;
        chk("rsp_after_stall", {rsp_valid, rsp_write, rsp_err, rsp_rdata}, {1'b1, 1'b0, 1'b0, 32'h1050});
        @(negedge clk);
        drive(0, 0, 32'h0, 32'h0, 1, 32'h0);
        #1;
        chk("rsp2_after_stall", {rsp_valid, rsp_write, rsp_err, rsp_rdata}, {1'b1, 1'b0, 1'b0, 32'h1054});
        @(negedge clk);
`else
        // Timeout of 4: first abort answers 0x50, the second answers 0x54
        bad = 0;
        for (int k = 0; k < 9; k++) begin
            drive(0, 0, 32'h0, 32'h0, 0, 32'hBAD);
            #1;
            if (k == 4 || k == 8)
                chk($sformatf("timeout_rsp_k%0d", k), {rsp_valid, rsp_write, rsp_err, rsp_rdata},
                    {1'b1, 1'b0, 1'b1, 32'h0});
            else if (rsp_valid !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("timeout_no_early_rsp", 128'(bad), 128'd0);
        drive(0, 0, 32'h0, 32'h0, 1, 32'h0);
        @(negedge clk);
`endif

        // Reset during a stalled write data phase
        drive(1, 1, 32'h44, 32'hDEAD, 1, 32'h0);
        @(negedge clk);
        drive(0, 0, 32'h0, 32'h0, 1, 32'h0);
        @(negedge clk);
        drive(0, 0, 32'h0, 32'h0, 0, 32'h0);
        #1;
        chk("hwdata_pre_reset", {HWRITE, HSEL, HWDATA}, {1'b1, 1'b0, 32'hDEAD});
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("reset_async",
            pack(cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err, HSEL, HTRANS, HADDR, HWRITE, HWDATA),
            pack(1, 0, 0, 32'h0, 0, 0, I, 32'h0, 0, 32'h0));
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 32'h0, 32'h0, 1, 32'h0);
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (rsp_valid !== 1'b0 || HSEL !== 1'b0 || HWDATA !== 32'h0) bad++;
            @(negedge clk);
        end
        chk("no_rsp_after_reset", 128'(bad), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ahb_lite_initiator.md
# ahb_lite_initiator

AHB-Lite single-master initiator that turns a simple valid/ready command stream (single read or write) into pipelined AHB-Lite transfers. It drives one AHB-Lite slave such as the GPIO peripheral, overlapping each command's address phase with the previous command's data phase. It returns one response per command. It is the initiator end of the bus the peripherals respond on, used by block benches and by the system controller.

## Interface
- ADDR_W, 32, address width of cmd_addr / HADDR
- DATA_W, 32, data width of cmd_wdata / HWDATA / HRDATA / rsp_rdata
- TIMEOUT_CYC, 16, consecutive wait-state cycles before a data phase is aborted; only used with the timeout feature; must be >= 1
- clk  in  1  single clock for all logic
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command can be accepted this cycle
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  transfer address
- cmd_wdata  in  DATA_W  write data, captured with the command
- rsp_valid  out  1  one-cycle response pulse, no backpressure
- rsp_write  out  1  response belongs to a write
- rsp_rdata  out  DATA_W  read data; 0 for writes
- rsp_err  out  1  transfer aborted by timeout
- HSEL  out  1  slave select, high during a valid address phase
- HADDR  out  ADDR_W  address-phase address
- HTRANS  out  2  IDLE (2'b00) or NONSEQ (2'b10) only
- HWRITE  out  1  address-phase direction
- HWDATA  out  DATA_W  data-phase write data
- HREADY  out  1  bus ready fed back to the slave; equals HREADYOUT (single-slave bus)
- HREADYOUT  in  1  slave ready
- HRDATA  in  DATA_W  slave read data

## Operation
- Two pipeline registers:
  - Address stage (ap_valid, ap_write, ap_addr, ap_wdata).
  - Data stage (dp_valid, dp_write, dp_wdata).
- Bus advance: any rising edge where HREADYOUT = 1.
- cmd_ready = !ap_valid || HREADYOUT. On cmd_valid && cmd_ready, the command loads the address stage.
- Address-phase outputs:
  - HSEL = ap_valid; HTRANS = ap_valid ? NONSEQ : IDLE.
  - HADDR / HWRITE come from the address stage.
  - When idle, HADDR and HWRITE hold their last values.
- On a bus advance:
  - The address stage moves to the data stage.
  - The address stage is reloaded if a command is accepted that same edge; otherwise it is cleared.
  - A valid data stage completes.
- HWDATA = dp_wdata while dp_valid; otherwise 0.
- Completion, registered: rsp_valid = 1 for exactly one cycle after the completing edge.
  - rsp_write = dp_write.
  - rsp_rdata = HRDATA sampled at that edge for reads, 0 for writes.
  - rsp_err = 0.
- A stalled slave (HREADYOUT = 0) freezes both stages and all AHB outputs.
- Responses are in command order; at most two commands are in flight.
- Reset values: cmd_ready 1, rsp_valid 0, rsp_write 0, rsp_rdata 0, rsp_err 0, HSEL 0, HTRANS IDLE, HADDR 0, HWRITE 0, HWDATA 0. Both stages are cleared.
- Reset mid-transfer drops all in-flight commands with no response.

## Timing
- Command accepted at edge N, slave has no wait states:
  - Address phase in cycle N..N+1, data phase N+1..N+2.
  - rsp_valid high in the cycle after edge N+2, i.e. latency of 2 edges.
- Each slave wait state adds one cycle.
- Back-to-back commands sustain one transfer per cycle.
- Accept and complete on the same edge are both honoured.

## Configuration
- AHB_INIT_TIMEOUT_EN defined:
  - A wait counter increments each cycle with dp_valid && !HREADYOUT, and clears on any advance.
  - When the counter reaches TIMEOUT_CYC, the data stage is treated as completed at that edge:
    - rsp_valid = 1, rsp_err = 1, rsp_rdata = 0.
    - The address stage advances as if HREADYOUT had been 1.
- AHB_INIT_TIMEOUT_EN undefined: no counter; the initiator waits indefinitely; rsp_err is tied to 0.

## Structure
- Shared package ahb_pkg holds:
  - HTRANS_IDLE / HTRANS_NONSEQ constants.
  - Typedef ahb_cmd_t {write, addr, wdata}.
  - Typedef ahb_rsp_t {write, rdata, err}.
- Optional sub-module ahb_init_timeout holds the wait counter and abort pulse; it is instantiated only under AHB_INIT_TIMEOUT_EN.

## Test plan
- Single write then read to the same address, HREADYOUT tied to 1:
  - HTRANS NONSEQ for 1 cycle each; HWDATA 0x0000_00A5 in the write data phase.
  - Read response rsp_rdata = 0x0000_00A5 two edges after acceptance.
- Four back-to-back reads with cmd_valid held high: cmd_ready stays 1 and four rsp_valid pulses arrive on consecutive cycles, in order.
- Slave inserts 3 wait states on the second of two writes:
  - HADDR, HWDATA and HTRANS stay frozen for 3 cycles; cmd_ready = 0 while the address stage is full.
  - The second response arrives 3 cycles late.
- Reset asserted during a stalled data phase: all outputs return to reset values immediately; no rsp_valid after reset release.
- With AHB_INIT_TIMEOUT_EN and TIMEOUT_CYC = 4, HREADYOUT held at 0 during a read data phase: after 4 stall cycles, rsp_valid = 1, rsp_err = 1, rsp_rdata = 0.
- Without AHB_INIT_TIMEOUT_EN, the same stimulus held for 100 cycles: no response and the bus remains frozen.
